regfile_seq_ctrl: RTL and testbench

//  Command sequencer for the 4x8-bit I/O data register file (write port D/addr/WE; registered read muxes cha/chb -> Da/Db).

---
 rtl/regfile_ctrl_pkg.sv | 29 ++
 rtl/regfile_seq_ctrl_guard.sv | 38 +++
 rtl/regfile_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_regfile_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file command sequencer:
// op encodings, FSM states, register indices and default widths.
package regfile_ctrl_pkg;

    localparam int DW = 8;
    localparam int AW = 2;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_WR  = 2'b01,
        OP_RD  = 2'b10,
        OP_MOV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SEL,
        S_CAPT,
        S_MOVW,
        S_RESP
    } state_e;

    localparam logic [1:0] REG_Q0 = 2'd0;
    localparam logic [1:0] REG_Q1 = 2'd1;
    localparam logic [1:0] REG_Q2 = 2'd2;
    localparam logic [1:0] REG_Q3 = 2'd3;

endpackage

// File: rtl/regfile_seq_ctrl_guard.sv
// rf_bus_guard: shadows the Q0 bus-enable bits and flags reads of a
// disabled tristate bus (B1 via Q0[0], B2 via Q0[1]).
module rf_bus_guard
    import regfile_ctrl_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [1:0]    en_d_i,
    input  logic [AW-1:0] sra_i,
    input  logic [AW-1:0] srb_i,
    output logic          block_o
);

    logic [1:0] shadow_en_q;
    logic       off_a;
    logic       off_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_en_q <= 2'b00;
        end else if (we_i && addr_i == AW'(REG_Q0)) begin
            shadow_en_q <= en_d_i;
        end
    end

    always_comb begin
        off_a = (sra_i == AW'(REG_Q1) && !shadow_en_q[0]) ||
                (sra_i == AW'(REG_Q2) && !shadow_en_q[1]);
        off_b = (srb_i == AW'(REG_Q1) && !shadow_en_q[0]) ||
                (srb_i == AW'(REG_Q2) && !shadow_en_q[1]);
        block_o = off_a || off_b;
    end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Command sequencer for the 4x8 I/O register file.
// Optional read guard on disabled buses: define BUS_GUARD_EN.
module regfile_seq_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_sra,
    input  logic [AW-1:0] cmd_srb,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_da,
    output logic [DW-1:0] rsp_db,
    output logic          rsp_err,
    output logic [DW-1:0] rf_d,
    output logic [AW-1:0] rf_addr,
    output logic          rf_we,
    output logic [AW-1:0] rf_cha,
    output logic [AW-1:0] rf_chb,
    input  logic [DW-1:0] rf_da,
    input  logic [DW-1:0] rf_db
);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] sra_q, sra_d;
    logic [AW-1:0] srb_q, srb_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] da_q, da_d;
    logic [DW-1:0] db_q, db_d;
    logic          err_q, err_d;
    logic          guard_block;

`ifdef BUS_GUARD_EN
    rf_bus_guard #(
        .AW(AW)
    ) u_guard (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (rf_we),
        .addr_i (rf_addr),
        .en_d_i (rf_d[1:0]),
        .sra_i  (sra_q),
        .srb_i  (srb_q),
        .block_o(guard_block)
    );
`else
    assign guard_block = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            dst_q   <= '0;
            sra_q   <= '0;
            srb_q   <= '0;
            data_q  <= '0;
            da_q    <= '0;
            db_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            sra_q   <= sra_d;
            srb_q   <= srb_d;
            data_q  <= data_d;
            da_q    <= da_d;
            db_q    <= db_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        sra_d   = sra_q;
        srb_d   = srb_q;
        data_d  = data_q;
        da_d    = da_q;
        db_d    = db_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = op_e'(cmd_op);
                    dst_d  = cmd_dst;
                    sra_d  = cmd_sra;
                    srb_d  = cmd_srb;
                    data_d = cmd_data;
                    da_d   = (op_e'(cmd_op) == OP_WR) ? cmd_data : '0;
                    db_d   = '0;
                    err_d  = 1'b0;
                    unique case (op_e'(cmd_op))
                        OP_NOP: state_d = S_RESP;
                        OP_WR:  state_d = S_WRITE;
                        OP_RD:  state_d = S_SEL;
                        OP_MOV: state_d = S_SEL;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_WRITE: state_d = S_RESP;
            S_SEL: begin
                if (guard_block) begin
                    err_d   = 1'b1;
                    da_d    = '0;
                    db_d    = '0;
                    state_d = S_RESP;
                end else begin
                    state_d = S_CAPT;
                end
            end
            // Register file has a registered mux: data valid one cycle after SEL
            S_CAPT: begin
                da_d    = rf_da;
                db_d    = (op_q == OP_RD) ? rf_db : '0;
                state_d = (op_q == OP_MOV) ? S_MOVW : S_RESP;
            end
            S_MOVW: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = rst_n && (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_da    = da_q;
        rsp_db    = db_q;
        rsp_err   = err_q;
        rf_we     = (state_q == S_WRITE) || (state_q == S_MOVW);
        rf_addr   = rf_we ? dst_q : '0;
        rf_d      = '0;
        if (state_q == S_WRITE) begin
            rf_d = data_q;
        end else if (state_q == S_MOVW) begin
            rf_d = da_q;
        end
        rf_cha = '0;
        rf_chb = '0;
        if (state_q == S_SEL || state_q == S_CAPT) begin
            rf_cha = sra_q;
            rf_chb = srb_q;
        end
    end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Randomized bench for regfile_seq_ctrl with a 4x8 register file model
// and a transaction-level reference of registers, shadow Q0 and latency.
module tb_regfile_seq_ctrl;

`ifdef BUS_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_sra;
    logic [1:0] cmd_srb;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_da;
    logic [7:0] rsp_db;
    logic       rsp_err;
    logic [7:0] rf_d;
    logic [1:0] rf_addr;
    logic       rf_we;
    logic [1:0] rf_cha;
    logic [1:0] rf_chb;
    logic [7:0] rf_da;
    logic [7:0] rf_db;

    logic [7:0] env [4];
    logic [7:0] mref [4];
    bit         known [4];
    logic [7:0] shadow;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) env[rf_addr] <= rf_d;
        rf_da <= env[rf_cha];
        rf_db <= env[rf_chb];
    end

    regfile_seq_ctrl #(.DW(8), .AW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_dst  (cmd_dst),
        .cmd_sra  (cmd_sra),
        .cmd_srb  (cmd_srb),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_da   (rsp_da),
        .rsp_db   (rsp_db),
        .rsp_err  (rsp_err),
        .rf_d     (rf_d),
        .rf_addr  (rf_addr),
        .rf_we    (rf_we),
        .rf_cha   (rf_cha),
        .rf_chb   (rf_chb),
        .rf_da    (rf_da),
        .rf_db    (rf_db)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit bus_off(input logic [1:0] r);
        return (r == 2'd1 && !shadow[0]) || (r == 2'd2 && !shadow[1]);
    endfunction

    task automatic cmp_regs();
        for (int i = 0; i < 4; i++)
            if (known[i]) chk($sformatf("reg%0d", i), env[i], mref[i]);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [1:0] dst,
                          input logic [1:0] sra, input logic [1:0] srb,
                          input logic [7:0] data, input int hold);
        bit         e_err;
        logic [7:0] e_da, e_db, wd;
        logic [1:0] wa;
        int         e_lat, e_we, n, lat, we_n;
        e_err = GUARD && (op >= 2'd2) && (bus_off(sra) || bus_off(srb));
        e_da = 8'h00;
        e_db = 8'h00;
        e_we = 0;
        case (op)
            2'd0: e_lat = 0;
            2'd1: begin e_lat = 1; e_da = data; e_we = 1; end
            2'd2: begin
                e_lat = e_err ? 1 : 2;
                if (!e_err) begin e_da = mref[sra]; e_db = mref[srb]; end
            end
            default: begin
                e_lat = e_err ? 1 : 3;
                if (!e_err) begin e_da = mref[sra]; e_we = 1; end
            end
        endcase
        cmd_op = op; cmd_dst = dst; cmd_sra = sra;
        cmd_srb = srb; cmd_data = data; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_timeout", 32'(n < 50), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0; we_n = 0; wa = 2'd0; wd = 8'd0;
        while (!rsp_valid && lat < 10) begin
            if (rf_we) begin we_n++; wa = rf_addr; wd = rf_d; end
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, e_lat);
        chk("we_cycles", we_n, e_we);
        if (e_we == 1) begin
            chk("we_addr", wa, dst);
            chk("we_data", wd, e_da);
            mref[dst] = e_da;
            known[dst] = 1'b1;
            if (dst == 2'd0) shadow = e_da;
        end
        chk("rsp_da", rsp_da, e_da);
        chk("rsp_db", rsp_db, e_db);
        chk("rsp_err", rsp_err, e_err);
        cmd_op = 2'd1; cmd_dst = 2'd0; cmd_data = 8'hFF;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_ready", cmd_ready, 1'b0);
            chk("hold_da", rsp_da, e_da);
            chk("hold_db", rsp_db, e_db);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", rsp_valid, 1'b0);
        cmp_regs();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            mref[i] = 8'h00;
            known[i] = 1'b0;
        end
        shadow = 8'h00;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 2'd0; cmd_dst = 2'd0; cmd_sra = 2'd0;
        cmd_srb = 2'd0; cmd_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rsp_da", rsp_da, 8'h00);
        rst_n = 1'b1;
        #1 chk("rel_cmd_ready", cmd_ready, 1'b1);

        do_cmd(2'd1, 2'd3, 2'd0, 2'd0, 8'hA5, 0);
        do_cmd(2'd2, 2'd0, 2'd3, 2'd3, 8'h00, 0);
        do_cmd(2'd1, 2'd0, 2'd0, 2'd0, 8'h03, 0);
        do_cmd(2'd1, 2'd1, 2'd0, 2'd0, 8'h5A, 0);
        do_cmd(2'd1, 2'd2, 2'd0, 2'd0, 8'hC3, 0);
        do_cmd(2'd2, 2'd0, 2'd1, 2'd2, 8'h00, 0);
        do_cmd(2'd3, 2'd3, 2'd1, 2'd1, 8'h00, 0);
        do_cmd(2'd2, 2'd0, 2'd3, 2'd0, 8'h00, 0);
        do_cmd(2'd2, 2'd0, 2'd2, 2'd1, 8'h00, 5);
        do_cmd(2'd0, 2'd0, 2'd0, 2'd0, 8'h77, 1);

        @(negedge clk);
        cmd_op = 2'd3; cmd_dst = 2'd2; cmd_sra = 2'd0;
        cmd_srb = 2'd0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("movw_we", rf_we, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_we", rf_we, 1'b0);
        chk("rst_mid_ready", cmd_ready, 1'b0);
        chk("rst_mid_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        shadow = 8'h00;
        #1 chk("rel2_cmd_ready", cmd_ready, 1'b1);
        chk("rel2_rsp_valid", rsp_valid, 1'b0);
        cmp_regs();
        @(negedge clk);

        do_cmd(2'd1, 2'd0, 2'd0, 2'd0, 8'h03, 0);
        do_cmd(2'd1, 2'd0, 2'd0, 2'd0, 8'h00, 0);
        do_cmd(2'd2, 2'd0, 2'd1, 2'd0, 8'h00, 0);
        do_cmd(2'd3, 2'd3, 2'd3, 2'd3, 8'h00, 0);

        for (int k = 0; k < 60; k++) begin
            do_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   8'($urandom), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
